// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the controller state encoding, the default operand width and
// the helper that sizes the iteration counter.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 16;
   localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

   // Counter width needed to count 0 .. width-1.
   function automatic int div_cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_sub.sv
// Subtract unit built in the adder style: diff = a + ~b + 1.
// borrow is the inverted carry out, so borrow=1 means a < b.
module div_sub_unit #(
   parameter int N = 17
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N:0] sum_s;

   // Add a to the one's complement of b with a forced carry-in of one.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
      diff   = sum_s[N-1:0];
      borrow = ~sum_s[N];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done
// handshake, quotient/remainder/div_by_zero held until the next accepted
// start. Optional signed mode is enabled with the DIV_SIGNED_EN macro.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
   input  logic             signed_op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int                CNT_W    = div_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             dvd_neg_s, dvs_neg_s;
   logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
   logic [2*WIDTH:0] pq_shift_s;
   logic [WIDTH:0]   p_shift_s;
   logic [WIDTH-1:0] acc_shift_s;
   logic [WIDTH:0]   trial_s;
   logic             borrow_s;
   logic [WIDTH:0]   p_next_s;
   logic [WIDTH-1:0] acc_next_s;

`ifdef DIV_SIGNED_EN
   assign dvd_neg_s = signed_op & dividend[WIDTH-1];
   assign dvs_neg_s = signed_op & divisor[WIDTH-1];
`else
   assign dvd_neg_s = 1'b0;
   assign dvs_neg_s = 1'b0;
`endif

   // Operand magnitudes; identical to the inputs in unsigned operation.
   always_comb begin
      dvd_mag_s = dvd_neg_s ? (~dividend + WIDTH'(1)) : dividend;
      dvs_mag_s = dvs_neg_s ? (~divisor + WIDTH'(1)) : divisor;
   end

   // Shift {P,Q} left by one; the P top bit drops out of the WIDTH+1 window.
   always_comb begin
      pq_shift_s  = {p_q, acc_q} << 1;
      p_shift_s   = pq_shift_s[2*WIDTH:WIDTH];
      acc_shift_s = pq_shift_s[WIDTH-1:0];
   end

   div_sub_unit #(
      .N (WIDTH + 1)
   ) u_sub (
      .a      (p_shift_s),
      .b      ({1'b0, dvs_q}),
      .diff   (trial_s),
      .borrow (borrow_s)
   );

   // Restore on borrow, otherwise keep the trial and set the quotient bit.
   always_comb begin
      p_next_s   = borrow_s ? p_shift_s : trial_s;
      acc_next_s = acc_shift_s | {{(WIDTH-1){1'b0}}, ~borrow_s};
   end

   // Next-state, datapath and result-register logic for the controller.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      p_d         = p_q;
      acc_d       = acc_q;
      dvs_d       = dvs_q;
      neg_quot_d  = neg_quot_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  state_d     = DONE;
                  quotient_d  = {WIDTH{1'b1}};
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d    = RUN;
                  count_d    = {CNT_W{1'b0}};
                  p_d        = {(WIDTH+1){1'b0}};
                  acc_d      = dvd_mag_s;
                  dvs_d      = dvs_mag_s;
                  neg_quot_d = dvd_neg_s ^ dvs_neg_s;
                  neg_rem_d  = dvd_neg_s;
                  dbz_d      = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            p_d     = p_next_s;
            acc_d   = acc_next_s;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_CNT) begin
               state_d     = DONE;
               quotient_d  = neg_quot_q ? (~acc_next_s + WIDTH'(1)) : acc_next_s;
               remainder_d = neg_rem_q ? (~p_next_s[WIDTH-1:0] + WIDTH'(1))
                                       : p_next_s[WIDTH-1:0];
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         count_q     <= {CNT_W{1'b0}};
         p_q         <= {(WIDTH+1){1'b0}};
         acc_q       <= {WIDTH{1'b0}};
         dvs_q       <= {WIDTH{1'b0}};
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         p_q         <= p_d;
         acc_q       <= acc_d;
         dvs_q       <= dvs_d;
         neg_quot_q  <= neg_quot_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=16): directed vector
// table, hand-written handshake/reset sequences and randomized operations
// compared against an arithmetic reference model.
module tb_seq_restoring_divider;

   localparam int W = 16;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         signed_op;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef DIV_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_z;
      int           exp_cyc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer division; zero divisor gives all ones / dividend.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z);
      longint sa, sb;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (busy && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Launch one operation; cyc = 1 means done visible right after the start edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] qo, output logic [W-1:0] ro,
                         output logic zo, output int cyc);
      wait_idle();
      start = 1'b1; dividend = a; divisor = b; signed_op = s;
      @(posedge Clk); #1;
      start = 1'b0; dividend = W'($urandom); divisor = W'($urandom); signed_op = 1'($urandom);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(posedge Clk); #1;
         cyc++;
      end
      qo = quotient; ro = remainder; zo = div_by_zero;
   endtask

   initial begin
      logic [W-1:0] gq, gr, eq, er, ra, rb;
      logic         gz, ez, rs;
      int           cyc, n, pulses, t1, t2;

      Reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;

      // Reset state after two low cycles.
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);

      // Directed vectors.
      vecs.push_back('{16'd100,  16'd7,      1'b0, 16'h000E, 16'd2,    1'b0, 17});
      vecs.push_back('{16'hFFFF, 16'h0001,   1'b0, 16'hFFFF, 16'h0000, 1'b0, 17});
      vecs.push_back('{16'h8000, 16'hFFFF,   1'b0, 16'h0000, 16'h8000, 1'b0, 17});
      vecs.push_back('{16'd3,    16'd10,     1'b0, 16'h0000, 16'd3,    1'b0, 17});
      vecs.push_back('{16'd5,    16'd0,      1'b0, 16'hFFFF, 16'd5,    1'b1, 1});
      vecs.push_back('{16'd9,    16'd3,      1'b0, 16'd3,    16'd0,    1'b0, 17});
`ifdef DIV_SIGNED_EN
      vecs.push_back('{16'hFFF9, 16'h0002,   1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17});
      vecs.push_back('{16'h0007, 16'hFFFE,   1'b1, 16'hFFFD, 16'h0001, 1'b0, 17});
      vecs.push_back('{16'h8000, 16'hFFFF,   1'b1, 16'h8000, 16'h0000, 1'b0, 17});
      vecs.push_back('{16'hFFF9, 16'h0000,   1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1});
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, gq, gr, gz, cyc);
         check($sformatf("vec%0d_quotient", i), 32'(gq), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d_remainder", i), 32'(gr), 32'(vecs[i].exp_r));
         check($sformatf("vec%0d_dbz", i), 32'(gz), 32'(vecs[i].exp_z));
         check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         @(posedge Clk); #1;
         check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
      end

      // start pulsed mid-run with new operands must be ignored.
      wait_idle();
      start = 1'b1; dividend = 16'd100; divisor = 16'd7; signed_op = 1'b0;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      @(posedge Clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge Clk); #1;
         n++;
      end
      check("ignored_start_quotient", 32'(quotient), 32'd14);
      check("ignored_start_remainder", 32'(remainder), 32'd2);
      check("ignored_start_latency", 32'(n + 6), 32'd17);

      // Reset in the middle of a run abandons it.
      wait_idle();
      start = 1'b1; dividend = 16'd200; divisor = 16'd3;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (7) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remainder", 32'(remainder), 32'd0);
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge Clk); #1;
         if (done) pulses++;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);

      // start held high: back-to-back operations every W+2 cycles.
      wait_idle();
      start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
      t1 = -1; t2 = -1;
      for (int k = 0; k < 60; k++) begin
         @(posedge Clk); #1;
         if (done && t1 < 0) t1 = k;
         else if (done && t2 < 0) t2 = k;
      end
      start = 1'b0;
      check("b2b_period", 32'(t2 - t1), 32'(W + 2));
      check("b2b_quotient", 32'(quotient), 32'd111);
      check("b2b_remainder", 32'(remainder), 32'd1);

      // Randomized operations against the reference model.
      for (int k = 0; k < 150; k++) begin
         n  = int'($urandom_range(0, 9));
         ra = W'($urandom);
         rb = (n == 0) ? '0 : (n < 4) ? W'($urandom_range(1, 15)) : W'($urandom);
         if (n == 9) begin ra = 16'h8000; rb = 16'hFFFF; end
`ifdef DIV_SIGNED_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         ref_div(ra, rb, rs, eq, er, ez);
         run_op(ra, rb, rs, gq, gr, gz, cyc);
         check($sformatf("rand%0d_quotient", k), 32'(gq), 32'(eq));
         check($sformatf("rand%0d_remainder", k), 32'(gr), 32'(er));
         check($sformatf("rand%0d_dbz", k), 32'(gz), 32'(ez));
         check($sformatf("rand%0d_latency", k), 32'(cyc), (rb == '0) ? 32'd1 : 32'(W + 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
